alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
//   16-bit integer ALU for the execute stage of the pipelined processor.
//   - result: combinational function of in1, in2 and controlSignal.
//   - carry, zero, neg: held in an internal condition-code register (CCR),
//     updated on the clock edge according to the operation.
//   - The next instruction sees the flags of the previous one.
//
// PARAMETERS
//   W     16   datapath width (in1, in2, result)
//   SHW   4    shift-amount width = $clog2(W); shift amount = in2[SHW-1:0]
//
// PORTS
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous, active-high reset; clears the CCR
//   in1            in   W   operand A
//   in2            in   W   operand B / shift amount
//   controlSignal  in   4   operation select (table below)
//   result         out  W   combinational operation result
//   carry          out  1   CCR carry flag (registered)
//   zero           out  1   CCR zero flag (registered)
//   neg            out  1   CCR negative flag (registered)
//
// BEHAVIOUR
//   - One clock. Reset is synchronous and active-high.
//   - Reset: on a posedge with rst=1, carry=zero=neg=0, regardless of the
//     operation in progress. result stays combinational and is unaffected.
//   - Latency:
//     - result: 0 cycles.
//     - Flags: visible after the next posedge (1 cycle).
//   - Flag terms:
//     - Z = (result==0)
//     - N = result[W-1]
//     - "ZN": Z and N update from result.
//     - "hold": the flag keeps its value.
//   - Operation table:
//     - 0 ADD   in1+in2; C=carry-out of bit W-1; ZN
//     - 1 SUB   in1-in2; C=borrow (in1<in2 unsigned); ZN
//     - 2 AND   in1&in2; C hold; ZN
//     - 3 OR    in1|in2; C hold; ZN
//     - 4 NOT   ~in1; C hold; ZN
//     - 5 INC   in1+1; C=carry-out; ZN
//     - 6 SHL   in1<<sh, where sh=in2[SHW-1:0]; C=in1[W-sh] (last bit out); ZN
//     - 7 SHR   logical in1>>sh; C=in1[sh-1]; ZN
//     - 8 SETC  result=in1; C=1; Z,N hold
//     - 9 DEC   in1-1; C=borrow (in1==0); ZN
//     - 10 XOR  in1^in2; C hold; ZN
//     - 11 CLRC result=in1; C=0; Z,N hold
//     - 12 MOV  result=in2; all flags hold
//     - 13-15 NOP result=in1; all flags hold
//   - Arithmetic is unsigned and modulo 2^W; overflow is not flagged.
//   - Shift by 0 (sh==0): result=in1, C holds, ZN update.
//   - Wrap cases:
//     - INC of 0xFFFF -> 0x0000, C=1, Z=1.
//     - DEC of 0x0000 -> 0xFFFF, C=1, N=1.
//   - Simultaneous rst=1 and a flag-writing op: reset wins.
//
// STRUCTURE
//   - Shared package alu_pkg: W, SHW, and the opcode localparams
//     (OP_ADD..OP_NOP) for the decode stage to share.
//   - One natural sub-module: alu_ccr, the 3-bit flag register with
//     per-flag write enables and synchronous reset.
//   - Datapath (result mux, carry/borrow, shifter with last-bit-out
//     extraction) stays in alu.
//
// TESTING
//   - ADD, op0, in1=0xFFFF, in2=0xFFFB -> result=0xFFFA; after posedge C=1,
//     N=1, Z=0.
//   - SUB, op1, in1=20, in2=0xFFFF -> result=0x0015, C=1, Z=0, N=0.
//     Then SUB 30-20 -> result=0x000A, C=0.
//   - INC, op5, in1=0xFFFF -> result=0, C=1, Z=1.
//     Then DEC, op9, in1=0 -> result=0xFFFF, C=1, N=1.
//   - SHL, op6, in1=3, in2=10 -> result=0x0C00, C=0.
//     SHR, op7, in1=10, in2=5 -> result=0, Z=1, C=0.
//     SHR in1=10, in2=2 -> result=2, C=1.
//   - Flag ops:
//     - SETC -> C=1, Z/N unchanged.
//     - CLRC -> C=0.
//     - MOV (op12) in2=0 -> result=0, Z unchanged.
//     - NOP (op15) -> all flags hold.
//   - Reset: set C/Z/N via ADD 0xFFFF+1, then assert rst with op0 still
//     applied -> all flags 0 after that posedge; result still 0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, shift-amount width, opcode encodings
// and the bit positions of the flags inside the condition-code register.
package alu_pkg;

  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  localparam int NFLAGS = 3;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SETC = 4'd8;
  localparam logic [3:0] OP_DEC  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_CLRC = 4'd11;
  localparam logic [3:0] OP_MOV  = 4'd12;
  localparam logic [3:0] OP_NOP  = 4'd13;

endpackage

// File: rtl/alu_ccr.sv
// Condition-code register: one flip-flop per flag, each with its own write
// enable, all cleared together by the synchronous reset.
module alu_ccr
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] flag_we,
  input  logic [NFLAGS-1:0] flag_d,
  output logic [NFLAGS-1:0] flag_q
);

  logic [NFLAGS-1:0] flag_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NFLAGS; gi = gi + 1) begin : g_flag
      // Reset dominates; otherwise load the new flag value only when enabled.
      always_ff @(posedge clk) begin
        if (rst)
          flag_reg[gi] <= 1'b0;
        else if (flag_we[gi])
          flag_reg[gi] <= flag_d[gi];
      end
    end
  endgenerate

  assign flag_q = flag_reg;

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational result, with carry/zero/negative flags
// captured in a CCR so that each instruction sees its predecessor's flags.
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [3:0]   controlSignal,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         neg
);

  logic [SHW-1:0]    sh;
  logic [W:0]        add_sum;
  logic [W:0]        sub_diff;
  logic [W:0]        inc_sum;
  logic [W:0]        dec_diff;
  logic [W:0]        shl_wide;
  logic [W:0]        shr_wide;
  logic              c_next;
  logic              c_we;
  logic              zn_we;
  logic [NFLAGS-1:0] flag_we;
  logic [NFLAGS-1:0] flag_d;
  logic [NFLAGS-1:0] flag_q;

  assign sh = in2[SHW-1:0];

  // One extra bit on each arithmetic path: for add/inc it is the carry-out,
  // for sub/dec it goes high exactly when the subtraction borrows.
  assign add_sum  = {1'b0, in1} + {1'b0, in2};
  assign sub_diff = {1'b0, in1} - {1'b0, in2};
  assign inc_sum  = {1'b0, in1} + (W+1)'(1);
  assign dec_diff = {1'b0, in1} - (W+1)'(1);

  // Shifting through a one-bit extension catches the last bit shifted out:
  // bit W for left shifts, bit 0 for right shifts.
  assign shl_wide = {1'b0, in1} << sh;
  assign shr_wide = {in1, 1'b0} >> sh;

  // Operation decode: result mux plus which flags this opcode writes.
  always_comb begin
    result = in1;
    c_next = 1'b0;
    c_we   = 1'b0;
    zn_we  = 1'b0;
    case (controlSignal)
      OP_ADD:  begin result = add_sum[W-1:0];  c_next = add_sum[W];  c_we = 1'b1; zn_we = 1'b1; end
      OP_SUB:  begin result = sub_diff[W-1:0]; c_next = sub_diff[W]; c_we = 1'b1; zn_we = 1'b1; end
      OP_AND:  begin result = in1 & in2; zn_we = 1'b1; end
      OP_OR:   begin result = in1 | in2; zn_we = 1'b1; end
      OP_NOT:  begin result = ~in1;      zn_we = 1'b1; end
      OP_INC:  begin result = inc_sum[W-1:0];  c_next = inc_sum[W];  c_we = 1'b1; zn_we = 1'b1; end
      // A zero shift moves no bit out, so the carry is left alone.
      OP_SHL:  begin result = shl_wide[W-1:0]; c_next = shl_wide[W]; c_we = (sh != '0); zn_we = 1'b1; end
      OP_SHR:  begin result = shr_wide[W:1];   c_next = shr_wide[0]; c_we = (sh != '0); zn_we = 1'b1; end
      OP_SETC: begin result = in1; c_next = 1'b1; c_we = 1'b1; end
      OP_DEC:  begin result = dec_diff[W-1:0]; c_next = dec_diff[W]; c_we = 1'b1; zn_we = 1'b1; end
      OP_XOR:  begin result = in1 ^ in2; zn_we = 1'b1; end
      OP_CLRC: begin result = in1; c_next = 1'b0; c_we = 1'b1; end
      OP_MOV:  begin result = in2; end
      default: begin result = in1; end
    endcase
  end

  assign flag_we[FLAG_C] = c_we;
  assign flag_we[FLAG_Z] = zn_we;
  assign flag_we[FLAG_N] = zn_we;
  assign flag_d[FLAG_C]  = c_next;
  assign flag_d[FLAG_Z]  = (result == '0);
  assign flag_d[FLAG_N]  = result[W-1];

  alu_ccr u_ccr (
    .clk     (clk),
    .rst     (rst),
    .flag_we (flag_we),
    .flag_d  (flag_d),
    .flag_q  (flag_q)
  );

  assign carry = flag_q[FLAG_C];
  assign zero  = flag_q[FLAG_Z];
  assign neg   = flag_q[FLAG_N];

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: a table of operations applied in order; the result is
// checked combinationally and the expected flags are queued and compared
// after the following clock edge. Hand-written sequences cover reset.
module tb_alu;
  import alu_pkg::*;

  logic         clk;
  logic         rst;
  logic [15:0]  in1;
  logic [15:0]  in2;
  logic [3:0]   controlSignal;
  logic [15:0]  result;
  logic         carry;
  logic         zero;
  logic         neg;

  int checks;
  int errors;

  // flags packed as {carry, zero, neg}
  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  f;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];
  logic [2:0] exp_q [$];

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .in1           (in1),
    .in2           (in2),
    .controlSignal (controlSignal),
    .result        (result),
    .carry         (carry),
    .zero          (zero),
    .neg           (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Drive one operation, check the result now, queue the flags for after the edge.
  task automatic apply(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] r, input logic [2:0] f);
    logic [2:0] ef;
    controlSignal = op;
    in1 = a;
    in2 = b;
    #1;
    check({name, " result"}, result, r);
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    ef = exp_q.pop_front();
    check({name, " flags"}, {13'd0, carry, zero, neg}, {13'd0, ef});
    $display("%s op=%0d in1=0x%04h in2=0x%04h result=0x%04h czn=%b%b%b",
             name, op, a, b, result, carry, zero, neg);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_ADD,  16'hFFFF, 16'hFFFB, 16'hFFFA, 3'b101};
    vecs[1]  = '{OP_SUB,  16'd20,   16'hFFFF, 16'h0015, 3'b100};
    vecs[2]  = '{OP_SUB,  16'd30,   16'd20,   16'h000A, 3'b000};
    vecs[3]  = '{OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 3'b110};
    vecs[4]  = '{OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 3'b101};
    vecs[5]  = '{OP_SHL,  16'd3,    16'd10,   16'h0C00, 3'b000};
    vecs[6]  = '{OP_SHR,  16'd10,   16'd5,    16'h0000, 3'b010};
    vecs[7]  = '{OP_SHR,  16'd10,   16'd2,    16'h0002, 3'b100};
    vecs[8]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 3'b100};
    vecs[9]  = '{OP_OR,   16'h8000, 16'h0001, 16'h8001, 3'b101};
    vecs[10] = '{OP_NOT,  16'hFFFF, 16'h1234, 16'h0000, 3'b110};
    vecs[11] = '{OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 3'b101};
    vecs[12] = '{OP_CLRC, 16'h1234, 16'h0000, 16'h1234, 3'b001};
    vecs[13] = '{OP_SETC, 16'h0000, 16'h0000, 16'h0000, 3'b101};
    vecs[14] = '{OP_MOV,  16'h0005, 16'h0000, 16'h0000, 3'b101};
    vecs[15] = '{4'd15,   16'h0000, 16'h0007, 16'h0000, 3'b101};
    vecs[16] = '{OP_SHL,  16'h8000, 16'h0001, 16'h0000, 3'b110};
    vecs[17] = '{OP_CLRC, 16'h0000, 16'h0000, 16'h0000, 3'b010};
    vecs[18] = '{OP_SHL,  16'h8001, 16'h0010, 16'h8001, 3'b001};
    vecs[19] = '{OP_SHR,  16'h8001, 16'h000F, 16'h0001, 3'b000};
    vecs[20] = '{OP_SHR,  16'h4001, 16'h000F, 16'h0000, 3'b110};
    vecs[21] = '{OP_SHL,  16'h0001, 16'h000F, 16'h8000, 3'b001};
    vecs[22] = '{OP_ADD,  16'h1234, 16'h1111, 16'h2345, 3'b000};
    vecs[23] = '{OP_DEC,  16'h0005, 16'h0000, 16'h0004, 3'b000};
    vecs[24] = '{OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 3'b001};
    vecs[25] = '{OP_NOP,  16'hABCD, 16'h0000, 16'hABCD, 3'b001};
    vecs[26] = '{4'd14,   16'h0001, 16'hFFFF, 16'h0001, 3'b001};

    // Reset state
    rst = 1'b1;
    controlSignal = OP_SETC;
    in1 = 16'h0000;
    in2 = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset flags", {13'd0, carry, zero, neg}, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);

    // Reset wins over a flag-writing op held on the inputs
    apply("preset add", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b110);
    rst = 1'b1;
    #1;
    check("rst result", result, 16'h0000);
    @(posedge clk);
    #1;
    check("rst flags", {13'd0, carry, zero, neg}, 16'd0);
    $display("reset with op=0 czn=%b%b%b", carry, zero, neg);
    rst = 1'b0;
    apply("post-rst nop", OP_NOP, 16'h0000, 16'h0000, 16'h0000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
